bubble_sorter_param: RTL and testbench

Parametrised serial-in/serial-out bubble sorter: accepts `N` unsigned words over a valid/ready stream, sorts them in place with one compare-exchange per clock, then streams them out in ascending or descending order. Sits in the Chapter 9 datapath examples as the generalised successor of the fixed 8×4-bit sorter. It adds runtime data load, a direction mode, stream handshakes and optional early termination.

---
 rtl/bubble_sorter_param_pkg.sv | 15 +
 rtl/bubble_sorter_param_cmp_swap.sv | 18 +
 rtl/bubble_sorter_param.sv | 131 +++++++++++++
 tb/tb_bubble_sorter_param.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bubble_sorter_param_pkg.sv
// rtl/bubble_sorter_param_pkg.sv - shared state encoding and width helper for the bubble sorter
package bubble_sort_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_LOAD  = 2'd0;
  localparam state_t S_SORT  = 2'd1;
  localparam state_t S_DRAIN = 2'd2;

  // Index width for an N-entry array; never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bubble_sorter_param_cmp_swap.sv
// rtl/bubble_sorter_param_cmp_swap.sv - combinational compare-exchange of two adjacent words
module cmp_swap #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             descend,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             swap
);

  // Strict comparison keeps equal words in place, so the sort is stable.
  assign swap   = descend ? (a < b) : (a > b);
  assign lo_out = swap ? b : a;
  assign hi_out = swap ? a : b;

endmodule

// File: rtl/bubble_sorter_param.sv
// rtl/bubble_sorter_param.sv - serial-in/serial-out bubble sorter; BUBBLE_SORT_EARLY_EXIT_EN enables early exit
module bubble_sorter_param
  import bubble_sort_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             descend,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = cw(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t           state;
  logic [WIDTH-1:0] mem [N];
  logic [CW-1:0]    wr_idx;
  logic [CW-1:0]    rd_idx;
  logic [CW-1:0]    j;
  logic [CW-1:0]    p;
  logic [CW-1:0]    jm1;
  logic             mode;
  logic [WIDTH-1:0] lo_w;
  logic [WIDTH-1:0] hi_w;
  logic             swap;
  logic             pass_clean;

  assign jm1 = j - ONE;

  cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
    .a       (mem[jm1]),
    .b       (mem[j]),
    .descend (mode),
    .lo_out  (lo_w),
    .hi_out  (hi_w),
    .swap    (swap)
  );

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
  logic swapped;
  // The compare in flight on the last cycle of a pass counts toward that pass.
  assign pass_clean = !(swapped || swap);
`else
  assign pass_clean = 1'b0;
`endif

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state == S_SORT);
  assign out_valid = (state == S_DRAIN);
  assign out_last  = out_valid && (rd_idx == LAST);
  assign out_data  = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_LOAD;
      wr_idx <= '0;
      rd_idx <= '0;
      j      <= '0;
      p      <= '0;
      mode   <= 1'b0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
      swapped <= 1'b0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            mem[wr_idx] <= in_data;
            if (wr_idx == LAST) begin
              wr_idx <= '0;
              mode   <= descend;
              p      <= ONE;
              j      <= LAST;
              state  <= S_SORT;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
              swapped <= 1'b0;
`endif
            end else begin
              wr_idx <= wr_idx + ONE;
            end
          end
        end
        S_SORT: begin
          if (swap) begin
            mem[jm1] <= lo_w;
            mem[j]   <= hi_w;
          end
          if (j > p) begin
            j <= j - ONE;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
            swapped <= swapped || swap;
`endif
          end else if ((p == LAST) || pass_clean) begin
            rd_idx <= '0;
            state  <= S_DRAIN;
          end else begin
            p <= p + ONE;
            j <= LAST;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
            swapped <= 1'b0;
`endif
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (rd_idx == LAST) begin
              rd_idx <= '0;
              wr_idx <= '0;
              state  <= S_LOAD;
            end else begin
              rd_idx <= rd_idx + ONE;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sorter_param.sv
// tb/tb_bubble_sorter_param.sv - table-driven scoreboard bench for bubble_sorter_param
module tb_bubble_sorter_param;

  localparam int N = 8;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         descend;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  bubble_sorter_param #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .descend   (descend),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] din;
    bit [31:0] dout;
    bit        desc;
    int        busy_full;
    int        busy_early;
    bit        bp;
    bit        gap;
  } vec_t;

  vec_t         vt[6];
  vec_t         v5;
  logic [W-1:0] sb[$];
  bit           rp[4];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_busy(input vec_t v);
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    return v.busy_early;
`else
    return v.busy_full;
`endif
  endfunction

  task automatic load(input bit [31:0] din, input bit desc, input bit gap);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < N && cyc < 200) begin
      @(negedge clk);
      in_valid = !(gap && (cyc % 3 == 1));
      in_data  = din[31-4*idx -: 4];
      descend  = desc;
      check("in_ready_load", {31'd0, in_ready}, 32'd1);
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    if (idx < N) check("load_timeout", idx, N);
  endtask

  task automatic run_job(input vec_t v);
    int           bc;
    int           k;
    int           cyc;
    bit           stalled;
    logic [W-1:0] held_d;
    logic         held_l;
    logic [W-1:0] e;
    for (int i = 0; i < N; i++) sb.push_back(v.dout[31-4*i -: 4]);
    load(v.din, v.desc, v.gap);
    // Junk on the input during sort/drain must be ignored; descend flips to prove it was latched.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'hF;
    descend  = !v.desc;
    check("busy_rise", {31'd0, busy}, 32'd1);
    bc = 0;
    while (busy && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    check("busy_cycles", bc, exp_busy(v));
    check("out_valid_rise", {31'd0, out_valid}, 32'd1);
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    while (k < N && cyc < 200) begin
      if (stalled) begin
        check("stall_data", {28'd0, out_data}, {28'd0, held_d});
        check("stall_last", {31'd0, out_last}, {31'd0, held_l});
      end
      out_ready = v.bp ? rp[cyc % 4] : 1'b1;
      check("out_valid", {31'd0, out_valid}, 32'd1);
      if (out_ready) begin
        if (sb.size() == 0) begin
          check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check("out_data", {28'd0, out_data}, {28'd0, e});
        end
        check("out_last", {31'd0, out_last}, (k == N - 1) ? 32'd1 : 32'd0);
        k++;
      end
      stalled = !out_ready;
      held_d  = out_data;
      held_l  = out_last;
      cyc++;
      @(negedge clk);
    end
    if (k < N) check("drain_timeout", k, N);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("in_ready_return", {31'd0, in_ready}, 32'd1);
    check("out_valid_fall", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    check({tag, "_out_data"}, {28'd0, out_data}, 32'd0);
  endtask

  initial begin
    int bc;
    rp = '{1'b1, 1'b0, 1'b0, 1'b1};
    //         din           dout          desc  full early bp    gap
    vt[0] = '{32'h81818181, 32'h11118888, 1'b0, 28, 25, 1'b0, 1'b0};
    vt[1] = '{32'h12345678, 32'h87654321, 1'b1, 28, 28, 1'b1, 1'b0};
    vt[2] = '{32'h12345678, 32'h12345678, 1'b0, 28,  7, 1'b0, 1'b1};
    vt[3] = '{32'h33333333, 32'h33333333, 1'b1, 28,  7, 1'b1, 1'b1};
    vt[4] = '{32'hFC993200, 32'hFC993200, 1'b1, 28,  7, 1'b1, 1'b0};
    vt[5] = '{32'h21345678, 32'h12345678, 1'b0, 28, 13, 1'b0, 1'b0};
    v5    = '{32'h55555555, 32'h55555555, 1'b0, 28,  7, 1'b1, 1'b1};

    rst = 1'b1;
    descend = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    for (int t = 0; t < 6; t++) run_job(vt[t]);

    // Abort a sort ten cycles in; the array must come back zeroed.
    load(vt[0].din, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    bc = 1;
    while (busy && bc < 10) begin
      bc++;
      @(negedge clk);
    end
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midsort_reset");

    run_job(v5);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
